// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed driver for a common-anode seven-segment
// display. A prescaler divides clk into per-digit slots; each slot starts
// with a short dark interval to suppress ghosting, then lights one digit.
// New values are double-buffered and only become visible at a frame boundary.
module seven_seg_mux #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int HEX_MODE     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [7:0]            segments,
    output logic                  frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]    DASH     = 7'b0000001;

    logic [CW-1:0]         count;
    logic [IW-1:0]         index;
    logic [4*DIGITS-1:0]   pend_data;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pend_lz;
    logic [4*DIGITS-1:0]   act_data;
    logic [DIGITS-1:0]     act_dp;
    logic                  act_lz;
    logic                  slot_end;
    logic                  run;
    logic [DIGITS-1:0]     lz_mask;
    logic [3:0]            nibble;
    logic                  cur_dp;
    logic [6:0]            pattern;
    logic                  blank_now;
    logic [DIGITS-1:0]     sel_next;
    logic [7:0]            seg_next;

    // Segment pattern in abcdefg order; the top six codes fall back to a
    // dash when the display is used for decimal-only values.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b1111110;
            4'h1: p = 7'b0110000;
            4'h2: p = 7'b1101101;
            4'h3: p = 7'b1111001;
            4'h4: p = 7'b0110011;
            4'h5: p = 7'b1011011;
            4'h6: p = 7'b1011111;
            4'h7: p = 7'b1110000;
            4'h8: p = 7'b1111111;
            4'h9: p = 7'b1111011;
            4'hA: p = (HEX_MODE != 0) ? 7'b1110111 : DASH;
            4'hB: p = (HEX_MODE != 0) ? 7'b0011111 : DASH;
            4'hC: p = (HEX_MODE != 0) ? 7'b1001110 : DASH;
            4'hD: p = (HEX_MODE != 0) ? 7'b0111101 : DASH;
            4'hE: p = (HEX_MODE != 0) ? 7'b1001111 : DASH;
            default: p = (HEX_MODE != 0) ? 7'b1000111 : DASH;
        endcase
        return p;
    endfunction

    assign slot_end   = (count == CNT_LAST);
    assign frame_done = slot_end && (index == IDX_LAST);

    // Prescaler and digit index: the index steps once per prescaler wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            index <= '0;
        end else if (slot_end) begin
            count <= '0;
            index <= (index == IDX_LAST) ? '0 : index + IW'(1);
        end else begin
            count <= count + CW'(1);
        end
    end

    // Double buffer: loads land in pending; active only changes at frame end,
    // taking a coincident load directly so it is not delayed a whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_lz   <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            act_lz    <= 1'b0;
        end else begin
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp;
                pend_lz   <= lz_blank;
            end
            if (frame_done) begin
                if (load) begin
                    act_data <= data;
                    act_dp   <= dp;
                    act_lz   <= lz_blank;
                end else begin
                    act_data <= pend_data;
                    act_dp   <= pend_dp;
                    act_lz   <= pend_lz;
                end
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while the digits stay
    // zero with no decimal point; digit 0 always stays visible.
    always_comb begin
        lz_mask = '0;
        run     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run = run && (act_data[4*i +: 4] == 4'd0) && !act_dp[i];
            if (i != 0) begin
                lz_mask[i] = act_lz && run;
            end
        end
    end

    // Next-state view of the outputs for the digit currently being scanned.
    always_comb begin
        nibble    = act_data[{index, 2'b00} +: 4];
        cur_dp    = act_dp[index];
        pattern   = decode(nibble);
        blank_now = (int'(count) < BLANK_CYCLES) || lz_mask[index];
        sel_next  = '1;
        seg_next  = 8'hFF;
        if (!blank_now) begin
            sel_next[index] = 1'b0;
            seg_next        = ~{cur_dp, pattern};
        end
    end

    // Registered pin drivers so the display lines are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_sel <= '1;
            segments  <= 8'hFF;
        end else begin
            digit_sel <= sel_next;
            segments  <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed scoreboard bench for seven_seg_mux with a small
// prescaler (8 cycles per slot, 2 dark cycles) so one frame is 32 cycles.
module tb_seven_seg_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  sel_h, sel_d;
    logic [7:0]  seg_h, seg_d;
    logic        fd_h, fd_d;

    typedef struct {
        int         cyc;
        int         unit;
        bit         chk_out;
        logic [3:0] sel;
        logic [7:0] seg;
        bit         chk_fd;
        logic       fd;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   base = 0;
    int   tests = 0;
    int   errors = 0;

    seven_seg_mux #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .HEX_MODE(1)) dut_hex (
        .clk(clk), .reset(reset), .load(load), .data(data), .dp(dp),
        .lz_blank(lz_blank), .digit_sel(sel_h), .segments(seg_h), .frame_done(fd_h)
    );

    seven_seg_mux #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .HEX_MODE(0)) dut_dec (
        .clk(clk), .reset(reset), .load(load), .data(data), .dp(dp),
        .lz_blank(lz_blank), .digit_sel(sel_d), .segments(seg_d), .frame_done(fd_d)
    );

    always #5 clk = ~clk;

    // Cycle number = count of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input exp_t e);
        logic [3:0] s;
        logic [7:0] g;
        logic       f;
        bit         ok;
        s  = (e.unit == 0) ? sel_h : sel_d;
        g  = (e.unit == 0) ? seg_h : seg_d;
        f  = (e.unit == 0) ? fd_h : fd_d;
        ok = 1'b1;
        if (e.chk_out && ((s !== e.sel) || (g !== e.seg))) ok = 1'b0;
        if (e.chk_fd && (f !== e.fd)) ok = 1'b0;
        tests++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d: got sel=%b seg=%h fd=%b, expected sel=%b seg=%h fd=%b",
                     e.name, cyc, s, g, f, e.sel, e.seg, e.fd);
        end
    endtask

    // Monitor: compare every scoreboard entry that falls due on this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                tests++;
                errors++;
                $display("[TB] FAIL %s missed: due cyc=%0d, now cyc=%0d", sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic pushExp(input int c, input int unit, input bit co, input logic [3:0] s,
                           input logic [7:0] g, input bit cf, input logic f, input string n);
        exp_t e;
        e.cyc = c; e.unit = unit; e.chk_out = co; e.sel = s; e.seg = g;
        e.chk_fd = cf; e.fd = f; e.name = n;
        sb.push_back(e);
    endtask

    // Outputs for scan state s appear after the following rising edge.
    task automatic expectOut(input int unit, input int s, input logic [3:0] sel,
                             input logic [7:0] seg, input string n);
        pushExp(base + s + 1, unit, 1'b1, sel, seg, 1'b0, 1'b0, n);
    endtask

    task automatic expectFd(input int s, input logic f, input string n);
        pushExp(base + s, 0, 1'b0, 4'hF, 8'hFF, 1'b1, f, n);
    endtask

    // One digit slot: two dark cycles, then lit at its first and last cycle.
    task automatic expectSlot(input int unit, input int frame, input int digit,
                              input logic [3:0] sel, input logic [7:0] seg, input string n);
        int s0;
        s0 = frame * 32 + digit * 8;
        expectOut(unit, s0,     4'hF, 8'hFF, {n, "_dark0"});
        expectOut(unit, s0 + 1, 4'hF, 8'hFF, {n, "_dark1"});
        expectOut(unit, s0 + 2, sel,  seg,   {n, "_lit_first"});
        expectOut(unit, s0 + 7, sel,  seg,   {n, "_lit_last"});
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        pushExp(cyc + 1, 0, 1'b1, 4'hF, 8'hFF, 1'b1, 1'b0, "reset_state");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base  = cyc;
    endtask

    // Pulse load so that it is sampled while the scanner is in state s.
    task automatic applyStimulus(input int s, input logic [15:0] d, input logic [3:0] p, input logic lz);
        while (cyc < base + s) @(negedge clk);
        if (cyc != base + s) begin
            tests++;
            errors++;
            $display("[TB] FAIL load_timing: at cyc=%0d, wanted cyc=%0d", cyc, base + s);
        end
        load = 1'b1; data = d; dp = p; lz_blank = lz;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic drainWait();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            foreach (sb[i]) $display("[TB] FAIL %s timeout: still pending at cyc=%0d", sb[i].name, cyc);
            tests  += sb.size();
            errors += sb.size();
            sb.delete();
        end
    endtask

    initial begin
        // Plain scan with nothing loaded: every digit shows 0.
        doReset();
        expectSlot(0, 0, 0, 4'b1110, 8'h81, "t1_d0");
        expectSlot(0, 0, 1, 4'b1101, 8'h81, "t1_d1");
        expectFd(7,  1'b0, "t1_fd_slot0_end");
        expectFd(30, 1'b0, "t1_fd_before");
        expectFd(31, 1'b1, "t1_fd_frame_end");
        expectFd(32, 1'b0, "t1_fd_after");
        expectFd(63, 1'b1, "t1_fd_frame1_end");
        drainWait();

        // Load mid-frame: held back until the frame boundary.
        doReset();
        expectSlot(0, 0, 0, 4'b1110, 8'h81, "t2_f0_d0");
        expectSlot(0, 0, 3, 4'b0111, 8'h81, "t2_f0_d3");
        expectSlot(0, 1, 0, 4'b1110, 8'hB8, "t2_f1_d0");
        expectSlot(0, 1, 1, 4'b1101, 8'h88, "t2_f1_d1");
        expectSlot(0, 1, 2, 4'b1011, 8'h92, "t2_f1_d2");
        expectSlot(0, 1, 3, 4'b0111, 8'hCF, "t2_f1_d3");
        applyStimulus(5, 16'h12AF, 4'b0000, 1'b0);
        drainWait();

        // Decimal-only build shows a dash for hex nibbles.
        doReset();
        expectSlot(1, 1, 0, 4'b1110, 8'hA4, "t3_dec_d0");
        expectSlot(1, 1, 1, 4'b1101, 8'hFE, "t3_dec_d1_dash");
        expectSlot(1, 1, 2, 4'b1011, 8'h81, "t3_dec_d2");
        expectSlot(0, 1, 1, 4'b1101, 8'hE0, "t3_hex_d1_b");
        applyStimulus(3, 16'h00B5, 4'b0000, 1'b0);
        drainWait();

        // Leading-zero blanking, a decimal point stopping it, and all-zero data.
        doReset();
        expectSlot(0, 1, 0, 4'b1110, 8'h81, "t4_f1_d0");
        expectSlot(0, 1, 1, 4'b1101, 8'hA4, "t4_f1_d1");
        expectSlot(0, 1, 2, 4'b1111, 8'hFF, "t4_f1_d2_blank");
        expectSlot(0, 1, 3, 4'b1111, 8'hFF, "t4_f1_d3_blank");
        expectSlot(0, 2, 0, 4'b1110, 8'h81, "t4_f2_d0");
        expectSlot(0, 2, 1, 4'b1101, 8'hA4, "t4_f2_d1");
        expectSlot(0, 2, 2, 4'b1011, 8'h81, "t4_f2_d2");
        expectSlot(0, 2, 3, 4'b0111, 8'h01, "t4_f2_d3_dp");
        expectSlot(0, 3, 0, 4'b1110, 8'h81, "t4_f3_d0_kept");
        expectSlot(0, 3, 1, 4'b1111, 8'hFF, "t4_f3_d1_blank");
        expectSlot(0, 3, 3, 4'b1111, 8'hFF, "t4_f3_d3_blank");
        applyStimulus(3,  16'h0050, 4'b0000, 1'b1);
        applyStimulus(42, 16'h0050, 4'b1000, 1'b1);
        applyStimulus(70, 16'h0000, 4'b0000, 1'b1);
        drainWait();

        // Load on the frame_done cycle, then two loads in one frame.
        doReset();
        expectFd(31, 1'b1, "t5_fd_at_load");
        expectSlot(0, 1, 0, 4'b1110, 8'h8F, "t5_f1_d0_immediate");
        expectSlot(0, 2, 0, 4'b1110, 8'h8F, "t5_f2_d0_pending_kept");
        expectSlot(0, 3, 0, 4'b1110, 8'h04, "t5_f3_d0_last_load");
        expectSlot(0, 3, 1, 4'b1101, 8'h81, "t5_f3_d1");
        applyStimulus(31, 16'h0007, 4'b0000, 1'b0);
        applyStimulus(70, 16'h0003, 4'b0000, 1'b0);
        applyStimulus(80, 16'h0009, 4'b0001, 1'b0);
        drainWait();

        // Reset in the middle of digit 2 with a competing load.
        doReset();
        expectOut(0, 50, 4'b1011, 8'h86, "t6_d2_before_reset");
        pushExp(base + 53, 0, 1'b1, 4'hF, 8'hFF, 1'b1, 1'b0, "t6_reset_midslot");
        applyStimulus(31, 16'h4321, 4'b0000, 1'b0);
        while (cyc < base + 52) @(negedge clk);
        reset = 1'b1; load = 1'b1; data = 16'hFFFF; dp = 4'hF; lz_blank = 1'b0;
        repeat (2) @(negedge clk);
        load  = 1'b0;
        reset = 1'b0;
        base  = cyc;
        expectSlot(0, 0, 0, 4'b1110, 8'h81, "t6_restart_d0");
        expectSlot(0, 0, 1, 4'b1101, 8'h81, "t6_restart_d1");
        expectFd(31, 1'b1, "t6_fd_after_restart");
        expectSlot(0, 1, 0, 4'b1110, 8'h81, "t6_f1_d0_zero");
        expectSlot(0, 1, 2, 4'b1011, 8'h81, "t6_f1_d2_zero");
        drainWait();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
